muladd_operand_fetch: RTL and testbench

- Operand-fetch stage for the fused multiply-add path; sits directly downstream of the rs3 source-select mux.
- Accepts the rs1/rs2 addresses, the selected rs3 address and the rs3 select code. Reads a 3-read/1-write register file held inside the block.
- Presents the three operands to the execute stage through a one-entry registered valid/ready pipeline stage.
- Keeps held operands coherent with writebacks that land while the stage is stalled.

---
 rtl/muladd_operand_fetch_if.sv | 34 +++
 rtl/muladd_operand_fetch.sv | 111 +++++++++++
 tb/tb_muladd_operand_fetch.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/muladd_operand_fetch_if.sv
// Request/response bundle between the rs3 select mux, the operand-fetch
// stage and the execute stage of the fused multiply-add path.
//   request : in_valid, in_ready, rs1, rs2, rs3, rs3_sel
//   response: out_valid, out_ready, op1, op2, op3, op3_used
// master : the surrounding pipeline (drives requests, consumes operands)
// slave  : muladd_operand_fetch
interface muladd_operand_fetch_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [ADDR_WIDTH-1:0] rs3;
  logic [1:0]            rs3_sel;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic [DATA_WIDTH-1:0] op3;
  logic                  op3_used;

  modport master (
    output in_valid, rs1, rs2, rs3, rs3_sel, out_ready,
    input  in_ready, out_valid, op1, op2, op3, op3_used
  );

  modport slave (
    input  in_valid, rs1, rs2, rs3, rs3_sel, out_ready,
    output in_ready, out_valid, op1, op2, op3, op3_used
  );
endinterface

// File: rtl/muladd_operand_fetch.sv
// Operand-fetch stage for the fused multiply-add path. Holds a 3-read /
// 1-write register file and presents rs1/rs2/rs3 operands to execute
// through a one-entry registered valid/ready stage.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   flush            drop the held entry; writeback still commits
//   bus (slave)      request in / operands out handshake bundle
//   wr_en/addr/data  register file writeback
module muladd_operand_fetch #(
  parameter int         ADDR_WIDTH          = 5,
  parameter int         NUMBER_OF_REGISTERS = 32,
  parameter int         DATA_WIDTH          = 32,
  parameter logic [1:0] MULADD              = 2'b10,
  parameter int         ZERO_REG            = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  muladd_operand_fetch_if.slave bus,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam logic [ADDR_WIDTH:0] NREG = NUMBER_OF_REGISTERS[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] rf [NUMBER_OF_REGISTERS];

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q, op3_q;
  logic                  op3_used_q;
  logic [ADDR_WIDTH-1:0] h_rs1, h_rs2, h_rs3;

  logic                  accept;
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] rd1, rd2, rd3;

  // Backed by real storage: in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < NREG) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_commit    = wr_en && addr_ok(wr_addr);
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Read with write bypass; only writes that actually commit are bypassed,
  // so dropped writes never leak into an operand.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    rd3 = '0;
    if (addr_ok(bus.rs1)) rd1 = rf[bus.rs1];
    if (addr_ok(bus.rs2)) rd2 = rf[bus.rs2];
    if (addr_ok(bus.rs3)) rd3 = rf[bus.rs3];
    if (wr_commit && (wr_addr == bus.rs1)) rd1 = wr_data;
    if (wr_commit && (wr_addr == bus.rs2)) rd2 = wr_data;
    if (wr_commit && (wr_addr == bus.rs3)) rd3 = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUMBER_OF_REGISTERS; i++) rf[i] <= '0;
    end else if (wr_commit) begin
      rf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      op3_q       <= '0;
      op3_used_q  <= 1'b0;
      h_rs1       <= '0;
      h_rs2       <= '0;
      h_rs3       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      op1_q       <= rd1;
      op2_q       <= rd2;
      h_rs1       <= bus.rs1;
      h_rs2       <= bus.rs2;
      h_rs3       <= bus.rs3;
      if (bus.rs3_sel == MULADD) begin
        op3_q      <= rd3;
        op3_used_q <= 1'b1;
      end else begin
        op3_q      <= '0;
        op3_used_q <= 1'b0;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end else if (out_valid_q) begin
      // Stalled entry tracks writebacks so it never goes stale while held.
      if (wr_commit && (wr_addr == h_rs1)) op1_q <= wr_data;
      if (wr_commit && (wr_addr == h_rs2)) op2_q <= wr_data;
      if (op3_used_q && wr_commit && (wr_addr == h_rs3)) op3_q <= wr_data;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.op1       = op1_q;
  assign bus.op2       = op2_q;
  assign bus.op3       = op3_q;
  assign bus.op3_used  = op3_used_q;

endmodule

// File: tb/tb_muladd_operand_fetch.sv
module tb_muladd_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muladd_operand_fetch_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  muladd_operand_fetch #(
    .ADDR_WIDTH(5), .NUMBER_OF_REGISTERS(32), .DATA_WIDTH(32),
    .MULADD(2'b10), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        in_valid;
    logic [4:0]  rs1, rs2, rs3;
    logic [1:0]  sel;
    logic        out_ready;
    logic        flush;
    logic        exp_ir;
    logic        exp_ov;
    logic [31:0] e1, e2, e3;
    logic        eu;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic iv, input logic [4:0] a1, a2, a3, input logic [1:0] s,
    input logic ordy, input logic fl, input logic ir, input logic ov,
    input logic [31:0] x1, x2, x3, input logic u);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.in_valid = iv; v.rs1 = a1; v.rs2 = a2; v.rs3 = a3; v.sel = s;
    v.out_ready = ordy; v.flush = fl; v.exp_ir = ir; v.exp_ov = ov;
    v.e1 = x1; v.e2 = x2; v.e3 = x3; v.eu = u;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    bus.in_valid = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.rs3 = '0;
    bus.rs3_sel = 2'b00; bus.out_ready = 1'b1;
  endtask

  task automatic check_ops(input string tag, input logic [31:0] x1, x2, x3, input logic u);
    chk({tag, ".op1"}, bus.op1, x1);
    chk({tag, ".op2"}, bus.op2, x2);
    chk({tag, ".op3"}, bus.op3, x3);
    chk({tag, ".op3_used"}, {31'd0, bus.op3_used}, {31'd0, u});
  endtask

  initial begin
    //           we wa     wd           iv rs1    rs2    rs3    sel    ordy fl ir ov e1        e2        e3        u
    vecs.push_back(mk(1, 5'd5, 32'h11,   0, 5'd0,  5'd0,  5'd0,  2'b00, 1, 0, 1, 0, 0,        0,        0,        0));
    vecs.push_back(mk(1, 5'd6, 32'h22,   0, 5'd0,  5'd0,  5'd0,  2'b00, 1, 0, 1, 0, 0,        0,        0,        0));
    vecs.push_back(mk(1, 5'd7, 32'h33,   0, 5'd0,  5'd0,  5'd0,  2'b00, 1, 0, 1, 0, 0,        0,        0,        0));
    vecs.push_back(mk(0, 5'd0, 32'h0,    1, 5'd5,  5'd6,  5'd7,  2'b10, 1, 0, 1, 1, 32'h11,   32'h22,   32'h33,   1));
    vecs.push_back(mk(0, 5'd0, 32'h0,    1, 5'd5,  5'd6,  5'd7,  2'b00, 1, 0, 1, 1, 32'h11,   32'h22,   0,        0));
    vecs.push_back(mk(1, 5'd9, 32'hABCD, 1, 5'd9,  5'd9,  5'd9,  2'b10, 1, 0, 1, 1, 32'hABCD, 32'hABCD, 32'hABCD, 1));
    vecs.push_back(mk(0, 5'd0, 32'h0,    1, 5'd1,  5'd2,  5'd4,  2'b10, 1, 0, 1, 1, 0,        0,        0,        1));
    // stall: request ignored, writebacks patch the held operands
    vecs.push_back(mk(1, 5'd4, 32'h55,   1, 5'd5,  5'd6,  5'd7,  2'b10, 0, 0, 0, 1, 0,        0,        32'h55,   1));
    vecs.push_back(mk(1, 5'd2, 32'h66,   0, 5'd0,  5'd0,  5'd0,  2'b00, 0, 0, 0, 1, 0,        32'h66,   32'h55,   1));
    // release: transfer and new accept on the same edge
    vecs.push_back(mk(0, 5'd0, 32'h0,    1, 5'd5,  5'd6,  5'd4,  2'b10, 1, 0, 1, 1, 32'h11,   32'h22,   32'h55,   1));
    vecs.push_back(mk(0, 5'd0, 32'h0,    0, 5'd0,  5'd0,  5'd0,  2'b00, 1, 0, 1, 0, 0,        0,        0,        0));
    // zero register
    vecs.push_back(mk(1, 5'd0, 32'hFFFF, 0, 5'd0,  5'd0,  5'd0,  2'b00, 1, 0, 1, 0, 0,        0,        0,        0));
    vecs.push_back(mk(0, 5'd0, 32'h0,    1, 5'd0,  5'd0,  5'd0,  2'b10, 1, 0, 1, 1, 0,        0,        0,        1));
    vecs.push_back(mk(1, 5'd0, 32'h1234, 1, 5'd0,  5'd5,  5'd6,  2'b10, 1, 0, 1, 1, 0,        32'h11,   32'h22,   1));
    vecs.push_back(mk(0, 5'd0, 32'h0,    0, 5'd0,  5'd0,  5'd0,  2'b00, 0, 0, 0, 1, 0,        32'h11,   32'h22,   1));
    // unused op3 ignores writebacks to its address while held
    vecs.push_back(mk(0, 5'd0, 32'h0,    1, 5'd5,  5'd6,  5'd7,  2'b00, 1, 0, 1, 1, 32'h11,   32'h22,   0,        0));
    vecs.push_back(mk(1, 5'd7, 32'h77,   0, 5'd0,  5'd0,  5'd0,  2'b00, 0, 0, 0, 1, 32'h11,   32'h22,   0,        0));
    // flush kills held entry and the simultaneous accept; write still lands
    vecs.push_back(mk(1, 5'd8, 32'h88,   1, 5'd1,  5'd1,  5'd1,  2'b10, 1, 1, 1, 0, 0,        0,        0,        0));
    vecs.push_back(mk(0, 5'd0, 32'h0,    1, 5'd8,  5'd7,  5'd5,  2'b10, 1, 0, 1, 1, 32'h88,   32'h77,   32'h11,   1));

    drive_idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_ops("reset", 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      bus.in_valid = vecs[i].in_valid; bus.rs1 = vecs[i].rs1; bus.rs2 = vecs[i].rs2;
      bus.rs3 = vecs[i].rs3; bus.rs3_sel = vecs[i].sel;
      bus.out_ready = vecs[i].out_ready; flush = vecs[i].flush;
      #2;
      chk($sformatf("v%0d.in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].exp_ir});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].exp_ov});
      if (vecs[i].exp_ov)
        check_ops($sformatf("v%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].eu);
    end

    // Mid-stream reset with a valid entry held; concurrent write is ignored.
    @(negedge clk);
    drive_idle();
    bus.out_ready = 1'b0;
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h99;
    @(posedge clk);
    #1;
    chk("mreset.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_ops("mreset", 0, 0, 0, 0);
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    #1;
    chk("mreset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1; bus.rs1 = 5'd5; bus.rs2 = 5'd7; bus.rs3 = 5'd3; bus.rs3_sel = 2'b10;
    @(posedge clk);
    #1;
    chk("mreset.rd1.out_valid", {31'd0, bus.out_valid}, 32'd1);
    check_ops("mreset.rd1", 0, 0, 0, 1);
    @(negedge clk);
    bus.rs1 = 5'd9; bus.rs2 = 5'd8; bus.rs3 = 5'd6;
    @(posedge clk);
    #1;
    chk("mreset.rd2.out_valid", {31'd0, bus.out_valid}, 32'd1);
    check_ops("mreset.rd2", 0, 0, 0, 1);

    @(negedge clk);
    drive_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
